// File: rtl/br_pkg.sv
// Shared definitions for the branch resolution/prediction unit: branch type
// codes and elaboration-time helpers for sizing and resetting the BHT.
package br_pkg;

    localparam logic [2:0] BR_NO   = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BLT  = 3'd2;
    localparam logic [2:0] BR_BNE  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;
    localparam logic [2:0] BR_JMP  = 3'd7;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Weakly-not-taken: the largest value whose MSB is still clear.
    function automatic int bht_reset_val(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/br_cmp.sv
// Purely combinational branch comparator: maps operands and branch type to
// the raw taken decision (not yet qualified by the EX valid bit).
module br_cmp
    import br_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [2:0]      br_type,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = (op1 == op2);
            BR_BNE:  taken = (op1 != op2);
            BR_BLT:  taken = ($signed(op1) <  $signed(op2));
            BR_BGE:  taken = ($signed(op1) >= $signed(op2));
            BR_BLTU: taken = (op1 <  op2);
            BR_BGEU: taken = (op1 >= op2);
            BR_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_predict_unit.sv
// Branch resolution plus PC-indexed saturating-counter predictor (BHT),
// mispredict detection and saturating branch/mispredict statistics.
module br_predict_unit
    import br_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_pred,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    input  logic [2:0]        br_type,
    output logic              br_taken,
    output logic              mispredict,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mis_count
);

    localparam int              IDX_W   = clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(bht_reset_val(CNT_W));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  r_bht [BHT_DEPTH];
    logic [STAT_W-1:0] r_br_count;
    logic [STAT_W-1:0] r_mis_count;

    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic              w_cmp_taken;
    logic              w_is_br;
    logic              w_train;
    logic              w_stat_ev;
    logic [CNT_W-1:0]  w_cnt_cur;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_unused_pc;

    br_cmp #(.XLEN(XLEN)) u_cmp (
        .op1     (op1),
        .op2     (op2),
        .br_type (br_type),
        .taken   (w_cmp_taken)
    );

    // Untagged, word-aligned indexing: aliasing between PCs is accepted.
    assign w_if_idx    = if_pc[IDX_W+1:2];
    assign w_ex_idx    = ex_pc[IDX_W+1:2];
    assign w_unused_pc = ^{if_pc[1:0], if_pc[XLEN-1:IDX_W+2], ex_pc[1:0], ex_pc[XLEN-1:IDX_W+2]};

    assign w_is_br    = (br_type != BR_NO);
    assign br_taken   = ex_valid & w_cmp_taken;
    assign mispredict = ex_valid & w_is_br & (br_taken != ex_pred);
    assign w_stat_ev  = ex_valid & ~ex_stall & w_is_br;
    assign w_train    = w_stat_ev & (br_type != BR_JMP);

    // No write-to-read bypass: a same-cycle update shows up one cycle later.
    assign pred_taken = r_bht[w_if_idx][CNT_W-1];
    assign w_cnt_cur  = r_bht[w_ex_idx];

    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (br_taken) begin
            if (w_cnt_cur != CNT_MAX) w_cnt_next = w_cnt_cur + CNT_W'(1);
        end else begin
            if (w_cnt_cur != '0) w_cnt_next = w_cnt_cur - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CNT_RST;
        end else if (w_train) begin
            r_bht[w_ex_idx] <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else if (stat_clr) begin
            r_br_count  <= '0;
            r_mis_count <= '0;
        end else if (w_stat_ev) begin
            if (r_br_count != '1) r_br_count <= r_br_count + STAT_W'(1);
            if (mispredict && (r_mis_count != '1)) r_mis_count <= r_mis_count + STAT_W'(1);
        end
    end

    assign br_count  = r_br_count;
    assign mis_count = r_mis_count;

endmodule

// File: tb/tb_br_predict_unit.sv
// Scoreboard bench for br_predict_unit: each step pushes the expected
// outputs from a small reference model and compares them on the falling edge.
module tb_br_predict_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic [31:0] ex_pc;
    logic        ex_pred;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  br_type;
    logic        br_taken;
    logic        mispredict;
    logic        stat_clr;
    logic [3:0]  br_count;
    logic [3:0]  mis_count;

    br_predict_unit #(.XLEN(32), .BHT_DEPTH(64), .CNT_W(2), .STAT_W(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .if_pc      (if_pc),
        .pred_taken (pred_taken),
        .ex_valid   (ex_valid),
        .ex_stall   (ex_stall),
        .ex_pc      (ex_pc),
        .ex_pred    (ex_pred),
        .op1        (op1),
        .op2        (op2),
        .br_type    (br_type),
        .br_taken   (br_taken),
        .mispredict (mispredict),
        .stat_clr   (stat_clr),
        .br_count   (br_count),
        .mis_count  (mis_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       pred;
        logic       taken;
        logic       mis;
        logic [3:0] brc;
        logic [3:0] misc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mbht[64];
    int   m_brc;
    int   m_misc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] t);
        int signed sa;
        int signed sb_v;
        sa   = a;
        sb_v = b;
        case (t)
            3'd1: return a == b;
            3'd2: return sa < sb_v;
            3'd3: return a != b;
            3'd4: return sa >= sb_v;
            3'd5: return a < b;
            3'd6: return a >= b;
            3'd7: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mbht[i] = 1;
        m_brc  = 0;
        m_misc = 0;
    endtask

    task automatic step(input string tag, input logic [31:0] ipc, input logic v, input logic s,
                        input logic [31:0] epc, input logic ep, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] t, input logic clr);
        exp_t e;
        exp_t got_e;
        logic tk;
        logic ms;
        int   ix;
        if_pc = ipc; ex_valid = v; ex_stall = s; ex_pc = epc; ex_pred = ep;
        op1 = a; op2 = b; br_type = t; stat_clr = clr;
        tk = v & ref_cmp(a, b, t);
        ms = v & (t != 3'd0) & (tk != ep);
        e.tag   = tag;
        e.pred  = (mbht[ipc[7:2]] >= 2);
        e.taken = tk;
        e.mis   = ms;
        e.brc   = 4'(m_brc);
        e.misc  = 4'(m_misc);
        sb.push_back(e);
        @(negedge clk);
        got_e = sb.pop_front();
        $display("txn %s pc=%0h t=%0d pred=%0b taken=%0b mis=%0b brc=%0d misc=%0d",
                 got_e.tag, ipc, t, pred_taken, br_taken, mispredict, br_count, mis_count);
        check({got_e.tag, "_pred"},  32'(pred_taken), 32'(got_e.pred));
        check({got_e.tag, "_taken"}, 32'(br_taken),   32'(got_e.taken));
        check({got_e.tag, "_mis"},   32'(mispredict), 32'(got_e.mis));
        check({got_e.tag, "_brc"},   32'(br_count),   32'(got_e.brc));
        check({got_e.tag, "_misc"},  32'(mis_count),  32'(got_e.misc));
        @(posedge clk);
        if (clr) begin
            m_brc = 0; m_misc = 0;
        end else if (v && !s && t != 3'd0) begin
            if (m_brc < 15) m_brc++;
            if (ms && m_misc < 15) m_misc++;
        end
        if (v && !s && t != 3'd0 && t != 3'd7) begin
            ix = epc[7:2];
            if (tk && mbht[ix] < 3) mbht[ix]++;
            else if (!tk && mbht[ix] > 0) mbht[ix]--;
        end
        #1;
    endtask

    task automatic idle(input string tag, input logic [31:0] ipc);
        step(tag, ipc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; if_pc = 32'h100; ex_valid = 1'b0; ex_stall = 1'b0; ex_pc = '0;
        ex_pred = 1'b0; op1 = '0; op2 = '0; br_type = 3'd0; stat_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pred", 32'(pred_taken), 32'd0);
        rstn = 1'b1;

        // 1: reset state
        idle("t1", 32'h100);

        // 2: comparator cases
        step("t2_blt",  32'h100, 1, 0, 32'h80, 0, 32'hFFFF_FFFF, 32'h1, 3'd2, 0);
        step("t2_bltu", 32'h100, 1, 0, 32'h80, 0, 32'hFFFF_FFFF, 32'h1, 3'd5, 0);
        step("t2_bgeu", 32'h100, 1, 0, 32'h80, 1, 32'h5, 32'h5, 3'd6, 0);
        step("t2_jmp",  32'h100, 1, 0, 32'h80, 0, 32'h0, 32'h9, 3'd7, 0);
        step("t2_nv",   32'h100, 0, 0, 32'h80, 0, 32'h3, 32'h3, 3'd7, 0);
        step("t2_clr",  32'h100, 0, 0, 32'h0, 0, 32'h0, 32'h0, 3'd0, 1);

        // 3: train 0x40 taken three times, predicted not-taken
        for (int i = 0; i < 3; i++)
            step($sformatf("t3_%0d", i), 32'h40, 1, 0, 32'h40, 0, 32'h7, 32'h7, 3'd1, 0);
        idle("t3_after", 32'h40);
        check("t3_pred_const", 32'(pred_taken), 32'd1);
        check("t3_mis_const",  32'(mis_count),  32'd3);
        step("t3_sat", 32'h40, 1, 0, 32'h40, 1, 32'h1, 32'h2, 3'd3, 0);
        step("t3_dn",  32'h40, 1, 0, 32'h40, 1, 32'h1, 32'h2, 3'd1, 0);
        idle("t3_keep", 32'h40);

        // 4: same-cycle read/write and stalled training
        step("t4_rw",   32'h0, 1, 0, 32'h0, 0, 32'h1, 32'h2, 3'd3, 0);
        idle("t4_next", 32'h0);
        check("t4_new_const", 32'(pred_taken), 32'd1);
        step("t4_stall", 32'h0, 1, 1, 32'h0, 1, 32'h1, 32'h2, 3'd1, 0);
        step("t4_stall2", 32'h0, 1, 1, 32'h0, 1, 32'h1, 32'h2, 3'd1, 0);
        idle("t4_held", 32'h0);

        // 5: aliasing of 0x0 and 0x100
        idle("t5_alias1", 32'h100);
        step("t5_nt0", 32'h100, 1, 0, 32'h0, 1, 32'h1, 32'h2, 3'd1, 0);
        step("t5_nt1", 32'h100, 1, 0, 32'h0, 1, 32'h1, 32'h2, 3'd1, 0);
        idle("t5_alias2", 32'h100);
        check("t5_alias_const", 32'(pred_taken), 32'd0);

        // 6: statistics saturation, clear priority, reset mid-sequence
        for (int i = 0; i < 20; i++)
            step($sformatf("t6_b%0d", i), 32'h300 + 32'(4 * i), 1, 0, 32'(32'h40 * i),
                 i[0], $urandom_range(0, 3), $urandom_range(0, 3), 3'(1 + (i % 6)), 0);
        check("t6_sat_const", 32'(br_count), 32'd15);
        step("t6_clr", 32'h40, 1, 0, 32'h40, 0, 32'h1, 32'h1, 3'd1, 1);
        check("t6_clr_brc", 32'(br_count), 32'd0);
        check("t6_clr_mis", 32'(mis_count), 32'd0);
        step("t6_pre", 32'h40, 1, 0, 32'h40, 0, 32'h1, 32'h1, 3'd1, 0);

        ex_valid = 1'b1; ex_stall = 1'b0; ex_pc = 32'h40; br_type = 3'd1;
        op1 = 32'h4; op2 = 32'h4; stat_clr = 1'b0;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 8; i++) begin
            if_pc = 32'(i * 32'h40);
            #1;
            check($sformatf("t6_rst_pred%0d", i), 32'(pred_taken), 32'd0);
        end
        check("t6_rst_brc", 32'(br_count), 32'd0);
        @(posedge clk);
        #1;
        if_pc = 32'h40;
        #1;
        check("t6_rst_held", 32'(pred_taken), 32'd0);
        rstn = 1'b1;
        step("t6_post", 32'h40, 1, 0, 32'h40, 0, 32'h6, 32'h6, 3'd1, 0);
        idle("t6_post2", 32'h40);
        check("t6_wnt_const", 32'(pred_taken), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
